prog_timer: RTL
===============

# prog_timer

Parametrised countdown timer for the FSM subsystem. It loads a seconds count on `start_timer` and decrements it once per second, derived from the system clock by an internal prescaler. It emits 1 Hz and 2 Hz single-cycle enables and flags expiry. Compared with the fixed 4-bit timer, it adds configurable width and clock rate, pause/resume, auto-reload, a one-cycle done pulse and a running status.

## Interface
- `CNT_W`, 4: width of the seconds count and load value (2..16).
- `TICKS_PER_SEC`, 2000: clock cycles per second; must be even and ≥ 4.
- `clock` in 1: single clock; everything is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `value` in CNT_W: load value, sampled when `start_timer` = 1.
- `start_timer` in 1: load `value` and start counting.
- `pause` in 1: level; freezes the countdown while high.
- `auto_reload` in 1: level; on reaching 0, reload the last loaded value and keep running.
- `expired` out 1: level; high in EXPIRED state.
- `done` out 1: one-cycle pulse when the count reaches 0.
- `one_hz_enable` out 1: one-cycle pulse per elapsed second.
- `two_hz_enable` out 1: one-cycle pulse per elapsed half-second.
- `counter` out CNT_W: current remaining seconds.
- `running` out 1: high in RUN state.

## Operation
- States:
  - IDLE (after reset).
  - RUN.
  - PAUSED.
  - EXPIRED.
- Reset values: state IDLE; `counter` = 0; prescaler = 0; `reload_val` = 0; all outputs 0.
- Priority: reset > `start_timer` > expiry/reload > `pause` > count.
- `start_timer` in any state:
  - `counter` ← `value`, `reload_val` ← `value`, prescaler ← 0.
  - If `value` ≠ 0, go to RUN. If `value` = 0, go to EXPIRED with `done` pulsed.
- RUN, `pause` = 0: prescaler increments and wraps from TICKS_PER_SEC−1 to 0.
- RUN, `pause` = 1: go to PAUSED. The prescaler does not advance that cycle.
- PAUSED: prescaler and `counter` frozen, no pulses. Return to RUN on the first cycle `pause` = 0, resuming the prescaler where it stopped.
- Half tick: prescaler == TICKS_PER_SEC/2 − 1 while advancing.
  - Registered effect: `two_hz_enable` = 1 next cycle.
- Full tick: prescaler == TICKS_PER_SEC − 1 while advancing.
  - Registered effect: `two_hz_enable` = 1, `one_hz_enable` = 1, `counter` ← `counter` − 1, all next cycle.
- Full tick with `counter` == 1:
  - `counter` ← 0 and `done` = 1.
  - If `auto_reload` = 1 and `reload_val` ≠ 0: the cycle after, `counter` ← `reload_val` and the state stays RUN. `counter` reads 0 for exactly one cycle.
  - Otherwise go to EXPIRED.
- EXPIRED: `expired` = 1, `counter` = 0, no pulses, prescaler held at 0. Leave only via `start_timer` or reset.
- `pause` and `auto_reload` are ignored in IDLE and EXPIRED.
- Arithmetic: `counter` never underflows. The decrement occurs only when `counter` ≥ 1. The prescaler width is clog2(TICKS_PER_SEC).

## Timing
- All outputs are registered and there is no combinational input→output path.
- `start_timer` sampled at edge E0:
  - `counter` = `value` and `running` = 1 after E0.
  - First `two_hz_enable` after edge E0 + TICKS_PER_SEC/2.
  - First `one_hz_enable` and `counter` = `value` − 1 after edge E0 + TICKS_PER_SEC.
- Full countdown from N with no pause: `done` and `expired` first high after edge E0 + N·TICKS_PER_SEC, in the same cycle.
- Each cycle spent in PAUSED extends all later events by one cycle.
- Asserting `start_timer` mid-count restarts cleanly. No pulse is emitted in the restart cycle.
- Asserting reset mid-count returns to the reset values on the next edge.

## Structure
- Shared package `timer_pkg`:
  - State enum: IDLE, RUN, PAUSED, EXPIRED.
  - Width helper constant `PRESC_W = $clog2(TICKS_PER_SEC)`.
- Sub-module `tick_prescaler`:
  - Parameter: TICKS_PER_SEC.
  - Inputs: `clock`, `reset`, `clear`, `advance`.
  - Outputs: `half_tick`, `full_tick`, combinational strobes on the terminal counts.
- Top level: FSM, counter and reload register, and registered output pulses.

## Test plan
All scenarios use TICKS_PER_SEC = 8 and CNT_W = 4.
- Reset then idle 20 cycles → all outputs 0, `counter` = 0, `running` = 0.
- start with `value` = 3 → `two_hz_enable` after edges E0+4, +8, +12, …; `one_hz_enable` and `counter` = 2, 1, 0 after edges E0+8, E0+16, E0+24; `done` and `expired` after edge E0+24; no pulses afterwards.
- `value` = 2, `pause` high for 5 cycles starting 3 cycles after start → `counter` = 1 after edge E0+13, `expired` after edge E0+21; no pulses while paused.
- `value` = 2, `auto_reload` = 1 → `counter` sequence 2, 1, 0 (one cycle), 2, 1, …; `done` pulses every 16 cycles; `expired` stays 0.
- start with `value` = 0 → `done` = 1 for one cycle and `expired` = 1 after edge E0; `running` = 0.
- Simultaneous `start_timer` (`value` = 5) and `pause` while running with `counter` = 1 → `counter` = 5, state RUN with `pause` ignored, prescaler 0; reset asserted mid-count → all reset values next cycle.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the programmable countdown timer.
//
// Contents:
//   timer_state_t : FSM state encoding (IDLE, RUN, PAUSED, EXPIRED)
//   presc_width() : width helper giving PRESC_W = $clog2(TICKS_PER_SEC),
//                   which every user evaluates as a localparam for its own
//                   TICKS_PER_SEC.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSED  = 2'd2,
      EXPIRED = 2'd3
   } timer_state_t;

   // Prescaler width for a given clock rate. The clamp keeps the result
   // legal for degenerate rates; real rates are always >= 4.
   function automatic int presc_width(input int ticks);
      return (ticks > 2) ? $clog2(ticks) : 1;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to half-second and full-second strobes.
//
// Parameters:
//   TICKS_PER_SEC : clock cycles per second (even, >= 4)
// Ports:
//   clock     in  : system clock, rising edge
//   reset     in  : synchronous active-high reset, count -> 0
//   clear     in  : synchronous restart of the count at 0
//   advance   in  : count one cycle; when low the count holds
//   half_tick out : combinational strobe, advancing on count TICKS_PER_SEC/2-1
//   full_tick out : combinational strobe, advancing on count TICKS_PER_SEC-1
module tick_prescaler
   import timer_pkg::*;
#(
   parameter int TICKS_PER_SEC = 2000
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic advance,
   output logic half_tick,
   output logic full_tick
);

   localparam int PRESC_W = presc_width(TICKS_PER_SEC);
   localparam logic [PRESC_W-1:0] HALF_LAST = PRESC_W'(TICKS_PER_SEC / 2 - 1);
   localparam logic [PRESC_W-1:0] FULL_LAST = PRESC_W'(TICKS_PER_SEC - 1);

   logic [PRESC_W-1:0] count;

   // Modulo-TICKS_PER_SEC counter. Clear wins over advance so that a restart
   // always begins a fresh second, and a held count lets a pause resume
   // exactly where it stopped.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (advance) begin
         if (count == FULL_LAST) begin
            count <= '0;
         end else begin
            count <= count + PRESC_W'(1);
         end
      end
   end

   // Strobes are qualified by advance so a frozen count on a terminal value
   // never produces repeated ticks.
   assign half_tick = advance && (count == HALF_LAST);
   assign full_tick = advance && (count == FULL_LAST);

endmodule

// File: rtl/prog_timer.sv
// Programmable countdown timer: loads a seconds count, decrements it once
// per second, supports pause/resume and auto-reload, and flags expiry.
//
// Parameters:
//   CNT_W         : width of the seconds count (2..16)
//   TICKS_PER_SEC : clock cycles per second (even, >= 4)
// Ports:
//   clock         in  : system clock, rising edge
//   reset         in  : synchronous active-high reset
//   value         in  : load value, sampled with start_timer
//   start_timer   in  : load value and start (restarts from any state)
//   pause         in  : level, freezes the countdown while high
//   auto_reload   in  : level, reload the last value on reaching zero
//   expired       out : level, high while expired
//   done          out : one-cycle pulse when the count reaches zero
//   one_hz_enable out : one-cycle pulse per elapsed second
//   two_hz_enable out : one-cycle pulse per elapsed half-second
//   counter       out : remaining seconds
//   running       out : level, high while actively counting
module prog_timer
   import timer_pkg::*;
#(
   parameter int CNT_W         = 4,
   parameter int TICKS_PER_SEC = 2000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [CNT_W-1:0] value,
   input  logic             start_timer,
   input  logic             pause,
   input  logic             auto_reload,
   output logic             expired,
   output logic             done,
   output logic             one_hz_enable,
   output logic             two_hz_enable,
   output logic [CNT_W-1:0] counter,
   output logic             running
);

   timer_state_t     state;
   logic [CNT_W-1:0] reload_val;
   logic             reload_pending;
   logic             active;
   logic             advance;
   logic             clear;
   logic             half_tick;
   logic             full_tick;

   // The prescaler only runs while a countdown is live. The cycle that leaves
   // PAUSED advances too, so every cycle spent paused delays later events by
   // exactly one cycle. A start restarts the second from zero, and IDLE and
   // EXPIRED keep the prescaler parked at zero.
   assign active  = (state == RUN) || (state == PAUSED);
   assign advance = active && !pause && !start_timer;
   assign clear   = start_timer || !active;

   tick_prescaler #(
      .TICKS_PER_SEC(TICKS_PER_SEC)
   ) u_prescaler (
      .clock    (clock),
      .reset    (reset),
      .clear    (clear),
      .advance  (advance),
      .half_tick(half_tick),
      .full_tick(full_tick)
   );

   // Main FSM with registered outputs. Pulses default low every cycle.
   // A load takes priority over everything, then the zero/reload handling,
   // then pause. When auto-reload fires, counter shows zero for one cycle
   // and reload_pending restores the reload value on the following edge,
   // independent of pause on that cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         counter        <= '0;
         reload_val     <= '0;
         reload_pending <= 1'b0;
         expired        <= 1'b0;
         done           <= 1'b0;
         one_hz_enable  <= 1'b0;
         two_hz_enable  <= 1'b0;
         running        <= 1'b0;
      end else begin
         done           <= 1'b0;
         one_hz_enable  <= 1'b0;
         two_hz_enable  <= 1'b0;
         reload_pending <= 1'b0;
         if (start_timer) begin
            counter    <= value;
            reload_val <= value;
            if (value != '0) begin
               state   <= RUN;
               running <= 1'b1;
               expired <= 1'b0;
            end else begin
               state   <= EXPIRED;
               running <= 1'b0;
               expired <= 1'b1;
               done    <= 1'b1;
            end
         end else begin
            unique case (state)
               RUN, PAUSED: begin
                  if (reload_pending) begin
                     counter <= reload_val;
                  end
                  if (pause) begin
                     state   <= PAUSED;
                     running <= 1'b0;
                  end else begin
                     state         <= RUN;
                     running       <= 1'b1;
                     two_hz_enable <= half_tick || full_tick;
                     if (full_tick) begin
                        one_hz_enable <= 1'b1;
                        if (counter == CNT_W'(1)) begin
                           counter <= '0;
                           done    <= 1'b1;
                           if (auto_reload && (reload_val != '0)) begin
                              reload_pending <= 1'b1;
                           end else begin
                              state   <= EXPIRED;
                              running <= 1'b0;
                              expired <= 1'b1;
                           end
                        end else if (counter != '0) begin
                           counter <= counter - CNT_W'(1);
                        end
                     end
                  end
               end
               default: begin
                  // IDLE and EXPIRED wait for a load; pause and auto_reload
                  // have no effect here.
               end
            endcase
         end
      end
   end

endmodule
